datapath_1: RTL and testbench
=============================

DATAPATH_1 -- requirements
Module: datapath_1

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: clr  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: PCout, Zlowout, MDRout, R2out, R4out  input  1 each  bus drive selects for PC, Z[31:0], MDR, R2, R4.
REQ-004 SHALL have: MARIn, ZIn, PCIn, MDRIn, IRIn, YIn  input  1 each  load enables for MAR, Z, PC, MDR, IR, Y.
REQ-005 SHALL have: R2In, R4In, R5In  input  1 each  load enables for R2, R4, R5.
REQ-006 SHALL have: IncPC  input  1  ALU op: increment bus value.
REQ-007 SHALL have: AND  input  1  ALU op: bitwise AND of Y and bus.
REQ-008 SHALL have: read  input  1  MDR source select (1 = Mdatain, 0 = bus).
REQ-009 SHALL have: Mdatain  input  32  memory data in.
REQ-010 SHALL have: BusMuxOut  output  32  current internal bus value.
REQ-011 SHALL have: R5q, PCq, IRq, MARq, Zlowq  output  32 each  current contents of R5, PC, IR, MAR, Z[31:0].

Function
REQ-012 SHALL contain 32-bit registers R2, R4, R5, PC, IR, MAR, MDR, Y and a 64-bit register Z (Zhigh:Zlow).
REQ-013 Bus SHALL be combinational; drive priority when several selects are high: MDRout > PCout > Zlowout > R2out > R4out; no select high -> bus = 0.
REQ-014 Every register with its In signal high SHALL load the bus value present just before the rising edge; registers with In low hold.
REQ-015 MDR SHALL load only when MDRIn=1, from Mdatain if read=1, else from bus; read=1 with MDRIn=0 leaves MDR unchanged.
REQ-016 ALU SHALL be combinational: AND=1 -> Y & bus; else IncPC=1 -> bus + 1 (mod 2^32); else bus passed through; AND takes priority if both high.
REQ-017 ALU result SHALL be zero-extended to 64 bits; Z loads it when ZIn=1.
REQ-018 Read-and-write of the same register in one cycle (e.g. Zlowout with ZIn, or PCout with PCIn) SHALL use the old value on the bus; the new value appears after the edge.
REQ-019 Single-cycle latency: any load is visible on the q outputs/bus in the cycle after the enabling edge.
REQ-020 No internal sequencing; all control comes from the input strobes each cycle.

Reset
REQ-021 clr=1 at a rising edge SHALL clear R2, R4, R5, PC, IR, MAR, MDR, Y, Z to 0, overriding any simultaneous load enable.
REQ-022 After reset, with all selects low, BusMuxOut and all q outputs SHALL read 0.
REQ-023 Reset asserted mid-sequence (e.g. during an AND step) SHALL discard the operation; the next cycle starts from all-zero state.

Verification
REQ-024 Reset: clr=1 one edge with ZIn=1, PCIn=1 also high -> PCq=0, Zlowq=0, all q outputs 0.
REQ-025 Register load: Mdatain=0x22, read=1, MDRIn=1 -> MDR=0x22; then MDRout=1, R2In=1 -> R2=0x22 on bus via R2out; likewise R4=0x44, R5=0x26; read=1 with MDRIn=0 leaves MDR unchanged.
REQ-026 Fetch from PC=0: T0 PCout, MARIn, IncPC, ZIn -> MARq=0, Zlowq=1; T1 Zlowout, PCIn, read, MDRIn, Mdatain=0x4A920000 -> PCq=1, MDR=0x4A920000; T2 MDRout, IRIn -> IRq=0x4A920000.
REQ-027 AND: T3 R2out, YIn -> Y=0x22; T4 R4out, AND, ZIn -> Zlowq=0x00000000; T5 Zlowout, R5In -> R5q changes 0x26 -> 0x00000000.
REQ-028 Priority/wrap: MDRout and R2out both high -> bus = MDR; bus 0xFFFFFFFF with IncPC, ZIn -> Zlowq=0, Zhigh=0.
REQ-029 Mid-operation reset: clr=1 on the T4 edge -> Zlowq=0, Y=0; T5 then loads 0 into R5.

Source files
------------

// File: rtl/datapath_1_if.sv
// Control strobes, memory data and observation outputs of the datapath_1 bus datapath.
interface datapath_1_if;
    logic        PCout, Zlowout, MDRout, R2out, R4out;
    logic        MARIn, ZIn, PCIn, MDRIn, IRIn, YIn;
    logic        R2In, R4In, R5In;
    logic        IncPC, AND, read;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut;
    logic [31:0] R5q, PCq, IRq, MARq, Zlowq;

    modport master (
        output PCout, Zlowout, MDRout, R2out, R4out,
        output MARIn, ZIn, PCIn, MDRIn, IRIn, YIn,
        output R2In, R4In, R5In,
        output IncPC, AND, read, Mdatain,
        input  BusMuxOut, R5q, PCq, IRq, MARq, Zlowq
    );

    modport slave (
        input  PCout, Zlowout, MDRout, R2out, R4out,
        input  MARIn, ZIn, PCIn, MDRIn, IRIn, YIn,
        input  R2In, R4In, R5In,
        input  IncPC, AND, read, Mdatain,
        output BusMuxOut, R5q, PCq, IRq, MARq, Zlowq
    );
endinterface

// File: rtl/datapath_1.sv
// Single-bus register datapath: prioritised bus mux, AND/increment ALU into 64-bit Z,
// every register loaded from the bus by its own strobe.
module datapath_1 (
    input  logic            clk,
    input  logic            clr,
    datapath_1_if.slave     dp
);
    logic [31:0] r2_q, r2_d, r4_q, r4_d, r5_q, r5_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d;
    logic [31:0] mdr_q, mdr_d, y_q, y_d;
    logic [63:0] z_q, z_d;
    logic [31:0] bus;
    logic [31:0] alu;

    always_comb begin
        bus = '0;
        if (dp.MDRout)       bus = mdr_q;
        else if (dp.PCout)   bus = pc_q;
        else if (dp.Zlowout) bus = z_q[31:0];
        else if (dp.R2out)   bus = r2_q;
        else if (dp.R4out)   bus = r4_q;
    end

    always_comb begin
        alu = bus;
        if (dp.AND)        alu = y_q & bus;
        else if (dp.IncPC) alu = bus + 32'd1;
    end

    // Loads see the pre-edge bus, so a register driving the bus while loading sees its old value.
    always_comb begin
        r2_d  = dp.R2In  ? bus : r2_q;
        r4_d  = dp.R4In  ? bus : r4_q;
        r5_d  = dp.R5In  ? bus : r5_q;
        pc_d  = dp.PCIn  ? bus : pc_q;
        ir_d  = dp.IRIn  ? bus : ir_q;
        mar_d = dp.MARIn ? bus : mar_q;
        y_d   = dp.YIn   ? bus : y_q;
        z_d   = dp.ZIn   ? {32'd0, alu} : z_q;
        mdr_d = mdr_q;
        if (dp.MDRIn) mdr_d = dp.read ? dp.Mdatain : bus;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r2_q  <= '0;
            r4_q  <= '0;
            r5_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            r2_q  <= r2_d;
            r4_q  <= r4_d;
            r5_q  <= r5_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            z_q   <= z_d;
        end
    end

    assign dp.BusMuxOut = bus;
    assign dp.R5q       = r5_q;
    assign dp.PCq       = pc_q;
    assign dp.IRq       = ir_q;
    assign dp.MARq      = mar_q;
    assign dp.Zlowq     = z_q[31:0];
endmodule

// File: tb/tb_datapath_1.sv
// Self-checking bench for datapath_1: directed vector table, hand sequences, then random strobes.
module tb_datapath_1;
    logic clk;
    logic clr;
    datapath_1_if dp ();

    datapath_1 dut (.clk(clk), .clr(clr), .dp(dp));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int unsigned B_PCO = 0,  B_ZLO = 1,  B_MDRO = 2, B_R2O = 3,  B_R4O = 4;
    localparam int unsigned B_MARI = 5, B_ZI = 6,   B_PCI = 7,  B_MDRI = 8, B_IRI = 9;
    localparam int unsigned B_YI = 10,  B_R2I = 11, B_R4I = 12, B_R5I = 13;
    localparam int unsigned B_INC = 14, B_AND = 15, B_RD = 16,  B_CLR = 17;

    localparam logic [17:0] PCO  = 18'd1 << B_PCO;
    localparam logic [17:0] ZLO  = 18'd1 << B_ZLO;
    localparam logic [17:0] MDRO = 18'd1 << B_MDRO;
    localparam logic [17:0] R2O  = 18'd1 << B_R2O;
    localparam logic [17:0] R4O  = 18'd1 << B_R4O;
    localparam logic [17:0] MARI = 18'd1 << B_MARI;
    localparam logic [17:0] ZI   = 18'd1 << B_ZI;
    localparam logic [17:0] PCI  = 18'd1 << B_PCI;
    localparam logic [17:0] MDRI = 18'd1 << B_MDRI;
    localparam logic [17:0] IRI  = 18'd1 << B_IRI;
    localparam logic [17:0] YI   = 18'd1 << B_YI;
    localparam logic [17:0] R2I  = 18'd1 << B_R2I;
    localparam logic [17:0] R4I  = 18'd1 << B_R4I;
    localparam logic [17:0] R5I  = 18'd1 << B_R5I;
    localparam logic [17:0] INC  = 18'd1 << B_INC;
    localparam logic [17:0] ANDO = 18'd1 << B_AND;
    localparam logic [17:0] RD   = 18'd1 << B_RD;
    localparam logic [17:0] CLR  = 18'd1 << B_CLR;
    localparam logic [17:0] NONE = 18'd0;

    typedef struct {
        logic [17:0] c;
        logic [31:0] md;
        bit          cb;
        logic [31:0] bus, pc, zl, mar, ir, r5;
    } vec_t;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference state: architectural registers as plain variables.
    logic [31:0] m_r2, m_r4, m_r5, m_pc, m_ir, m_mar, m_mdr, m_y;
    logic [63:0] m_z;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [17:0] c, input logic [31:0] md, input bit cb,
                                 input logic [31:0] bus, input logic [31:0] pc,
                                 input logic [31:0] zl, input logic [31:0] mar,
                                 input logic [31:0] ir, input logic [31:0] r5);
        vec_t v;
        v.c = c; v.md = md; v.cb = cb; v.bus = bus;
        v.pc = pc; v.zl = zl; v.mar = mar; v.ir = ir; v.r5 = r5;
        return v;
    endfunction

    function automatic logic [31:0] m_bus(input logic [17:0] c);
        logic [31:0] src [5];
        logic        sel [5];
        logic [31:0] v;
        src = '{m_mdr, m_pc, m_z[31:0], m_r2, m_r4};
        sel = '{c[B_MDRO], c[B_PCO], c[B_ZLO], c[B_R2O], c[B_R4O]};
        v = 32'd0;
        for (int i = 4; i >= 0; i--)
            if (sel[i]) v = src[i];
        return v;
    endfunction

    task automatic m_step(input logic [17:0] c, input logic [31:0] md);
        logic [31:0] b;
        logic [63:0] r;
        b = m_bus(c);
        if (c[B_AND])      r = {32'd0, m_y & b};
        else if (c[B_INC]) r = ({32'd0, b} + 64'd1) % 64'h1_0000_0000;
        else               r = {32'd0, b};
        if (c[B_CLR]) begin
            {m_r2, m_r4, m_r5, m_pc, m_ir, m_mar, m_mdr, m_y} = '0;
            m_z = '0;
        end else begin
            if (c[B_R2I])  m_r2  = b;
            if (c[B_R4I])  m_r4  = b;
            if (c[B_R5I])  m_r5  = b;
            if (c[B_PCI])  m_pc  = b;
            if (c[B_IRI])  m_ir  = b;
            if (c[B_MARI]) m_mar = b;
            if (c[B_YI])   m_y   = b;
            if (c[B_ZI])   m_z   = r;
            if (c[B_MDRI]) m_mdr = c[B_RD] ? md : b;
        end
    endtask

    task automatic drive(input logic [17:0] c, input logic [31:0] md);
        dp.PCout   = c[B_PCO];  dp.Zlowout = c[B_ZLO];  dp.MDRout = c[B_MDRO];
        dp.R2out   = c[B_R2O];  dp.R4out   = c[B_R4O];
        dp.MARIn   = c[B_MARI]; dp.ZIn     = c[B_ZI];   dp.PCIn   = c[B_PCI];
        dp.MDRIn   = c[B_MDRI]; dp.IRIn    = c[B_IRI];  dp.YIn    = c[B_YI];
        dp.R2In    = c[B_R2I];  dp.R4In    = c[B_R4I];  dp.R5In   = c[B_R5I];
        dp.IncPC   = c[B_INC];  dp.AND     = c[B_AND];  dp.read   = c[B_RD];
        dp.Mdatain = md;
        clr        = c[B_CLR];
    endtask

    // One cycle: apply strobes, sample the combinational bus before the edge, advance the model.
    task automatic run(input logic [17:0] c, input logic [31:0] md, output logic [31:0] bus_pre);
        @(negedge clk);
        drive(c, md);
        #1 bus_pre = dp.BusMuxOut;
        @(posedge clk);
        m_step(c, md);
        #1;
    endtask

    vec_t tbl [31];
    logic [31:0] bp, mb;
    logic [17:0] rc;
    logic [31:0] rmd;

    initial begin
        drive(NONE, 32'd0);
        clr = 1'b1;

        tbl[0]  = mkv(CLR|ZI|PCI,          32'd0,        0, 32'd0,        0, 0,          0, 0,            0);
        tbl[1]  = mkv(NONE,                32'd0,        1, 32'd0,        0, 0,          0, 0,            0);
        tbl[2]  = mkv(RD|MDRI,             32'h22,       1, 32'd0,        0, 0,          0, 0,            0);
        tbl[3]  = mkv(MDRO|R2I,            32'd0,        1, 32'h22,       0, 0,          0, 0,            0);
        tbl[4]  = mkv(RD|MDRI,             32'h44,       1, 32'd0,        0, 0,          0, 0,            0);
        tbl[5]  = mkv(MDRO|R4I,            32'd0,        1, 32'h44,       0, 0,          0, 0,            0);
        tbl[6]  = mkv(RD|MDRI,             32'h26,       1, 32'd0,        0, 0,          0, 0,            0);
        tbl[7]  = mkv(MDRO|R5I,            32'd0,        1, 32'h26,       0, 0,          0, 0,            32'h26);
        tbl[8]  = mkv(MDRO|RD,             32'h99,       1, 32'h26,       0, 0,          0, 0,            32'h26);
        tbl[9]  = mkv(MDRO|R2O,            32'd0,        1, 32'h26,       0, 0,          0, 0,            32'h26);
        tbl[10] = mkv(R2O,                 32'd0,        1, 32'h22,       0, 0,          0, 0,            32'h26);
        tbl[11] = mkv(R4O,                 32'd0,        1, 32'h44,       0, 0,          0, 0,            32'h26);
        tbl[12] = mkv(PCO|MARI|INC|ZI,     32'd0,        1, 32'd0,        0, 1,          0, 0,            32'h26);
        tbl[13] = mkv(ZLO|PCI|RD|MDRI,     32'h4A920000, 1, 32'd1,        1, 1,          0, 0,            32'h26);
        tbl[14] = mkv(MDRO|IRI,            32'd0,        1, 32'h4A920000, 1, 1,          0, 32'h4A920000, 32'h26);
        tbl[15] = mkv(R2O|YI,              32'd0,        1, 32'h22,       1, 1,          0, 32'h4A920000, 32'h26);
        tbl[16] = mkv(R4O|ANDO|ZI,         32'd0,        1, 32'h44,       1, 0,          0, 32'h4A920000, 32'h26);
        tbl[17] = mkv(ZLO|R5I,             32'd0,        1, 32'd0,        1, 0,          0, 32'h4A920000, 0);
        tbl[18] = mkv(PCO|PCI|INC|ZI,      32'd0,        1, 32'd1,        1, 2,          0, 32'h4A920000, 0);
        tbl[19] = mkv(ZLO|ZI|INC,          32'd0,        1, 32'd2,        1, 3,          0, 32'h4A920000, 0);
        tbl[20] = mkv(RD|MDRI,             32'hFFFFFFFF, 1, 32'd0,        1, 3,          0, 32'h4A920000, 0);
        tbl[21] = mkv(MDRO|INC|ZI,         32'd0,        1, 32'hFFFFFFFF, 1, 0,          0, 32'h4A920000, 0);
        tbl[22] = mkv(MDRO|YI,             32'd0,        1, 32'hFFFFFFFF, 1, 0,          0, 32'h4A920000, 0);
        tbl[23] = mkv(R4O|ANDO|INC|ZI,     32'd0,        1, 32'h44,       1, 32'h44,     0, 32'h4A920000, 0);
        tbl[24] = mkv(MDRO|R5I,            32'd0,        1, 32'hFFFFFFFF, 1, 32'h44,     0, 32'h4A920000, 32'hFFFFFFFF);
        tbl[25] = mkv(R2O|YI,              32'd0,        1, 32'h22,       1, 32'h44,     0, 32'h4A920000, 32'hFFFFFFFF);
        tbl[26] = mkv(R4O|ANDO|ZI|CLR,     32'd0,        1, 32'h44,       0, 0,          0, 0,            0);
        tbl[27] = mkv(ZLO|R5I,             32'd0,        1, 32'd0,        0, 0,          0, 0,            0);
        tbl[28] = mkv(RD|MDRI,             32'h22,       1, 32'd0,        0, 0,          0, 0,            0);
        tbl[29] = mkv(MDRO|ANDO|ZI,        32'd0,        1, 32'h22,       0, 0,          0, 0,            0);
        tbl[30] = mkv(MDRO|INC|ZI,         32'd0,        1, 32'h22,       0, 32'h23,     0, 0,            0);

        for (int i = 0; i < 31; i++) begin
            run(tbl[i].c, tbl[i].md, bp);
            if (tbl[i].cb) chk($sformatf("vec%0d bus", i), bp, tbl[i].bus);
            chk($sformatf("vec%0d PCq", i),   dp.PCq,   tbl[i].pc);
            chk($sformatf("vec%0d Zlowq", i), dp.Zlowq, tbl[i].zl);
            chk($sformatf("vec%0d MARq", i),  dp.MARq,  tbl[i].mar);
            chk($sformatf("vec%0d IRq", i),   dp.IRq,   tbl[i].ir);
            chk($sformatf("vec%0d R5q", i),   dp.R5q,   tbl[i].r5);
        end

        // Increment wrap leaves both halves of Z at zero.
        run(RD|MDRI, 32'hFFFFFFFF, bp);
        run(MDRO|INC|ZI, 32'd0, bp);
        chk("wrap bus", bp, 32'hFFFFFFFF);
        chk("wrap Zlow", dp.Zlowq, 32'd0);
        chk("wrap Zhigh", dut.z_q[63:32], 32'd0);

        // Reset overrides every simultaneous load enable.
        run(RD|MDRI, 32'h1234, bp);
        run(MDRO|PCI|MARI|IRI|R5I|ZI|YI|R2I|R4I|CLR, 32'd0, bp);
        chk("rst-ovr bus", bp, 32'h1234);
        chk("rst-ovr PCq", dp.PCq, 32'd0);
        chk("rst-ovr MARq", dp.MARq, 32'd0);
        chk("rst-ovr IRq", dp.IRq, 32'd0);
        chk("rst-ovr R5q", dp.R5q, 32'd0);
        chk("rst-ovr Zlowq", dp.Zlowq, 32'd0);
        run(MDRO, 32'd0, bp); chk("rst-ovr MDR", bp, 32'd0);
        run(R2O, 32'd0, bp);  chk("rst-ovr R2", bp, 32'd0);
        run(R4O, 32'd0, bp);  chk("rst-ovr R4", bp, 32'd0);
        run(RD|MDRI, 32'h5A, bp);
        run(MDRO|ANDO|ZI, 32'd0, bp);
        chk("rst-ovr Y", dp.Zlowq, 32'd0);

        for (int n = 0; n < 400; n++) begin
            rc = '0;
            for (int b = 0; b < 17; b++) rc[b] = ($urandom_range(2) == 0);
            rc[B_CLR] = ($urandom_range(23) == 0);
            rmd = $urandom;
            mb = m_bus(rc);
            run(rc, rmd, bp);
            chk("rnd bus", bp, mb);
            chk("rnd PCq", dp.PCq, m_pc);
            chk("rnd Zlowq", dp.Zlowq, m_z[31:0]);
            chk("rnd Zhigh", dut.z_q[63:32], m_z[63:32]);
            chk("rnd MARq", dp.MARq, m_mar);
            chk("rnd IRq", dp.IRq, m_ir);
            chk("rnd R5q", dp.R5q, m_r5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
